// File: rtl/t9990_pixel_mixer.sv
// ============================================================================
// Module   : t9990_pixel_mixer
// Purpose  : Bitmap/cursor/backdrop mix, frame-synchronous fade and
//            sync alignment for the T9990 video output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module t9990_pixel_mixer #(
  parameter int SYNC_DELAY = 2
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        DCLK_EN,
  input  logic [15:0] PIX_IN,
  input  logic [15:0] CUR_IN,
  input  logic        CUR_PRI,
  input  logic        TPE,
  input  logic        DISP,
  input  logic [14:0] BD_COLOR,
  input  logic [3:0]  FADE,
  input  logic        ACTIVE_IN,
  input  logic        HSYNC_IN,
  input  logic        VSYNC_IN,
  output logic [4:0]  R_OUT,
  output logic [4:0]  G_OUT,
  output logic [4:0]  B_OUT,
  output logic        HSYNC_OUT,
  output logic        VSYNC_OUT,
  output logic        DE_OUT
);

  logic w_act_d;
  logic w_hs_d;
  logic w_vs_d;

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign w_act_d = ACTIVE_IN;
      assign w_hs_d  = HSYNC_IN;
      assign w_vs_d  = VSYNC_IN;
    end else begin : g_delay
      // Each entry packs {active, hsync, vsync} for one dot-clock tick.
      logic [2:0] r_sr [SYNC_DELAY];

      always_ff @(posedge CLK) begin
        if (!RESET_n) begin
          for (int i = 0; i < SYNC_DELAY; i++) r_sr[i] <= 3'b000;
        end else if (DCLK_EN) begin
          r_sr[0] <= {ACTIVE_IN, HSYNC_IN, VSYNC_IN};
          for (int i = 1; i < SYNC_DELAY; i++) r_sr[i] <= r_sr[i-1];
        end
      end

      assign {w_act_d, w_hs_d, w_vs_d} = r_sr[SYNC_DELAY-1];
    end
  endgenerate

  logic [14:0] w_mix;
  logic        w_blank;
  logic        w_pix_transp;

  assign w_pix_transp = TPE & PIX_IN[15];

  always_comb begin
    w_mix   = PIX_IN[14:0];
    w_blank = 1'b0;
    if (!w_act_d) begin
      w_mix   = 15'd0;
      w_blank = 1'b1;
    end else if (!DISP) begin
      w_mix = BD_COLOR;
    end else if (!CUR_IN[15] && (CUR_PRI || w_pix_transp)) begin
      w_mix = CUR_IN[14:0];
    end else if (w_pix_transp) begin
      w_mix = BD_COLOR;
    end
  end

  logic [14:0] r_s1_color;
  logic        r_s1_blank;
  logic        r_s1_act;
  logic        r_s1_hs;
  logic        r_s1_vs;
  logic [3:0]  r_fade_cur;

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      r_s1_color <= 15'd0;
      r_s1_blank <= 1'b0;
      r_s1_act   <= 1'b0;
      r_s1_hs    <= 1'b0;
      r_s1_vs    <= 1'b0;
      r_fade_cur <= 4'd0;
    end else if (DCLK_EN) begin
      r_s1_color <= w_mix;
      r_s1_blank <= w_blank;
      r_s1_act   <= w_act_d;
      r_s1_hs    <= w_hs_d;
      r_s1_vs    <= w_vs_d;
      // r_s1_vs still holds last tick's vs_d, giving the rising-edge reference.
      if (w_vs_d && !r_s1_vs) r_fade_cur <= FADE;
    end
  end

  function automatic logic [4:0] fade_ch(input logic [4:0] c, input logic [3:0] f);
    logic [4:0] w_scale;
    logic [8:0] w_prod;
    w_scale = 5'd16 - {1'b0, f};
    w_prod  = {4'd0, c} * {4'd0, w_scale};
    return w_prod[8:4];
  endfunction

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      R_OUT     <= 5'd0;
      G_OUT     <= 5'd0;
      B_OUT     <= 5'd0;
      HSYNC_OUT <= 1'b0;
      VSYNC_OUT <= 1'b0;
      DE_OUT    <= 1'b0;
    end else if (DCLK_EN) begin
      if (r_s1_blank) begin
        R_OUT <= 5'd0;
        G_OUT <= 5'd0;
        B_OUT <= 5'd0;
      end else begin
        G_OUT <= fade_ch(r_s1_color[14:10], r_fade_cur);
        R_OUT <= fade_ch(r_s1_color[9:5],   r_fade_cur);
        B_OUT <= fade_ch(r_s1_color[4:0],   r_fade_cur);
      end
      HSYNC_OUT <= r_s1_hs;
      VSYNC_OUT <= r_s1_vs;
      DE_OUT    <= r_s1_act;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_t9990_pixel_mixer.sv
// ============================================================================
// Module   : tb_t9990_pixel_mixer
// Purpose  : Directed self-checking bench for t9990_pixel_mixer (SYNC_DELAY=2).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_t9990_pixel_mixer;

  logic        CLK = 1'b0;
  logic        RESET_n;
  logic        DCLK_EN;
  logic [15:0] PIX_IN;
  logic [15:0] CUR_IN;
  logic        CUR_PRI;
  logic        TPE;
  logic        DISP;
  logic [14:0] BD_COLOR;
  logic [3:0]  FADE;
  logic        ACTIVE_IN;
  logic        HSYNC_IN;
  logic        VSYNC_IN;
  logic [4:0]  R_OUT;
  logic [4:0]  G_OUT;
  logic [4:0]  B_OUT;
  logic        HSYNC_OUT;
  logic        VSYNC_OUT;
  logic        DE_OUT;

  int n_cmp = 0;
  int n_err = 0;

  t9990_pixel_mixer #(.SYNC_DELAY(2)) dut (
    .CLK       (CLK),
    .RESET_n   (RESET_n),
    .DCLK_EN   (DCLK_EN),
    .PIX_IN    (PIX_IN),
    .CUR_IN    (CUR_IN),
    .CUR_PRI   (CUR_PRI),
    .TPE       (TPE),
    .DISP      (DISP),
    .BD_COLOR  (BD_COLOR),
    .FADE      (FADE),
    .ACTIVE_IN (ACTIVE_IN),
    .HSYNC_IN  (HSYNC_IN),
    .VSYNC_IN  (VSYNC_IN),
    .R_OUT     (R_OUT),
    .G_OUT     (G_OUT),
    .B_OUT     (B_OUT),
    .HSYNC_OUT (HSYNC_OUT),
    .VSYNC_OUT (VSYNC_OUT),
    .DE_OUT    (DE_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the edge, outputs sampled there too.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic [15:0] rgb(input logic [4:0] r, input logic [4:0] g, input logic [4:0] b);
    return {1'b0, r, g, b};
  endfunction

  logic [15:0] w_obs_rgb;
  assign w_obs_rgb = {1'b0, R_OUT, G_OUT, B_OUT};

  function automatic logic hs_exp(input int n);
    return (n >= 4 && n <= 6);
  endfunction

  initial begin
    RESET_n = 1'b0; DCLK_EN = 1'b1;
    PIX_IN = 16'h7FFF; CUR_IN = 16'h8000; CUR_PRI = 1'b0; TPE = 1'b0;
    DISP = 1'b1; BD_COLOR = 15'd0; FADE = 4'd0;
    ACTIVE_IN = 1'b1; HSYNC_IN = 1'b0; VSYNC_IN = 1'b0;
    tick(3);
    check("reset_rgb", w_obs_rgb, 16'h0000);
    check("reset_de",  {15'd0, DE_OUT}, 16'h0000);
    check("reset_sync", {14'd0, HSYNC_OUT, VSYNC_OUT}, 16'h0000);

    // Active area reaches DE on the 4th tick after release.
    RESET_n = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tick(1);
      check($sformatf("startup_de_t%0d", t), {15'd0, DE_OUT}, 16'h0000);
      check($sformatf("startup_rgb_t%0d", t), w_obs_rgb, 16'h0000);
    end
    tick(1);
    check("startup_de_t4", {15'd0, DE_OUT}, 16'h0001);
    check("startup_rgb_t4", w_obs_rgb, rgb(5'd31, 5'd31, 5'd31));

    // Transparent bitmap pixel shows backdrop only when TPE is set.
    TPE = 1'b1; PIX_IN = 16'h8000; BD_COLOR = 15'h03E0; CUR_IN = 16'h8000;
    tick(2);
    check("tpe1_backdrop", w_obs_rgb, rgb(5'd31, 5'd0, 5'd0));
    TPE = 1'b0;
    tick(2);
    check("tpe0_pixel", w_obs_rgb, rgb(5'd0, 5'd0, 5'd0));

    // Cursor priority.
    CUR_IN = 16'h001F; PIX_IN = 16'h7C00; CUR_PRI = 1'b1;
    tick(2);
    check("curpri1", w_obs_rgb, rgb(5'd0, 5'd0, 5'd31));
    CUR_PRI = 1'b0;
    tick(2);
    check("curpri0", w_obs_rgb, rgb(5'd0, 5'd31, 5'd0));
    TPE = 1'b1; PIX_IN = 16'h8000;
    tick(2);
    check("cur_under_transp", w_obs_rgb, rgb(5'd0, 5'd0, 5'd31));
    TPE = 1'b0; CUR_IN = 16'h8000;

    // Blanking outside the active area, backdrop when display disabled.
    ACTIVE_IN = 1'b0; DISP = 1'b1; PIX_IN = 16'h7FFF;
    tick(4);
    check("blank_rgb", w_obs_rgb, 16'h0000);
    check("blank_de", {15'd0, DE_OUT}, 16'h0000);
    ACTIVE_IN = 1'b1; DISP = 1'b0; BD_COLOR = 15'h1234;
    tick(4);
    check("disp0_bd", w_obs_rgb, rgb(5'd17, 5'd4, 5'd20));
    check("disp0_de", {15'd0, DE_OUT}, 16'h0001);
    DISP = 1'b1;

    // Fade captured only on vs_d rising edge.
    PIX_IN = 16'h7FFF; FADE = 4'd8;
    tick(4);
    check("fade_midframe", w_obs_rgb, rgb(5'd31, 5'd31, 5'd31));
    VSYNC_IN = 1'b1;
    tick(3);
    check("fade_edge_tick", w_obs_rgb, rgb(5'd31, 5'd31, 5'd31));
    VSYNC_IN = 1'b0;
    tick(1);
    check("fade8", w_obs_rgb, rgb(5'd15, 5'd15, 5'd15));
    check("vsync_out", {15'd0, VSYNC_OUT}, 16'h0001);
    FADE = 4'd15;
    tick(6);
    check("fade_hold", w_obs_rgb, rgb(5'd15, 5'd15, 5'd15));
    check("vsync_out_low", {15'd0, VSYNC_OUT}, 16'h0000);
    VSYNC_IN = 1'b1;
    tick(3);
    VSYNC_IN = 1'b0;
    tick(1);
    check("fade15", w_obs_rgb, rgb(5'd1, 5'd1, 5'd1));

    // Sparse dot-clock enable: HSYNC pulse width and hold between enables.
    for (int n = 1; n <= 9; n++) begin
      DCLK_EN = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick(1);
        check($sformatf("hs_hold_n%0d_k%0d", n, k), {15'd0, HSYNC_OUT}, {15'd0, hs_exp(n-1)});
      end
      HSYNC_IN = (n >= 1 && n <= 3);
      DCLK_EN = 1'b1;
      tick(1);
      check($sformatf("hs_tick%0d", n), {15'd0, HSYNC_OUT}, {15'd0, hs_exp(n)});
    end
    HSYNC_IN = 1'b0;
    DCLK_EN = 1'b0;
    tick(1);
    check("pre_reset_de", {15'd0, DE_OUT}, 16'h0001);

    // Reset takes effect with DCLK_EN low.
    RESET_n = 1'b0;
    tick(1);
    check("reset_noen_de", {15'd0, DE_OUT}, 16'h0000);
    check("reset_noen_rgb", w_obs_rgb, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/t9990_pixel_mixer.md
Name: t9990_pixel_mixer

Overview:
- Output stage directly downstream of the T9990 colour-space decoder.
- Takes its 16-bit pixel word (bit15 = transparent, [14:10] G, [9:5] R, [4:0] B) and merges it with the cursor/sprite pixel and the backdrop colour.
- Applies a frame-synchronous fade and blanking, and delays the sync/active timing to match the pixel pipeline.
- Drives 5-bit RGB plus aligned HSYNC/VSYNC/DE to the video output encoder.

Parameters:
SYNC_DELAY, 2, DCLK_EN ticks of extra delay on ACTIVE/HSYNC/VSYNC to match upstream decoder latency (range 0..7)

Ports:
CLK  in  1  system clock
RESET_n  in  1  reset, synchronous, active-low
DCLK_EN  in  1  dot-clock enable; every pipeline register advances only when high
PIX_IN  in  16  decoded pixel {T,G5,R5,B5}; T=1 transparent
CUR_IN  in  16  cursor/sprite pixel, same format; T=1 means no cursor pixel
CUR_PRI  in  1  1: cursor above bitmap; 0: cursor only where bitmap transparent
TPE  in  1  transparency enable for bitmap bit15
DISP  in  1  display enable; 0 forces backdrop in active area
BD_COLOR  in  15  backdrop {G5,R5,B5}
FADE  in  4  fade level request, 0 = full brightness
ACTIVE_IN  in  1  active-area flag from timing generator, undelayed
HSYNC_IN  in  1  horizontal sync, active-high, undelayed
VSYNC_IN  in  1  vertical sync, active-high, undelayed
R_OUT  out  5  red
G_OUT  out  5  green
B_OUT  out  5  blue
HSYNC_OUT  out  1  aligned HSYNC
VSYNC_OUT  out  1  aligned VSYNC
DE_OUT  out  1  aligned data enable

Behaviour:
- Reset (RESET_n low at a CLK edge, regardless of DCLK_EN):
  - all pipeline, sync-delay and output registers clear to 0;
  - fade_cur clears to 0.
  - Reset mid-line yields black and DE=0 for SYNC_DELAY+2 ticks after release.
- Timing delay line:
  - ACTIVE/HSYNC/VSYNC pass through a SYNC_DELAY-deep shift register clocked on DCLK_EN.
  - SYNC_DELAY=0 means pass-through to stage 1.
  - Delayed signals are act_d, hs_d, vs_d.
- Stage 1 (mix, on DCLK_EN), in priority order:
  - act_d=0 -> colour 0, flag blank;
  - DISP=0 -> BD_COLOR;
  - CUR_IN[15]=0 and (CUR_PRI=1 or (TPE=1 and PIX_IN[15]=1)) -> CUR_IN[14:0];
  - TPE=1 and PIX_IN[15]=1 -> BD_COLOR;
  - otherwise -> PIX_IN[14:0].
  - With TPE=0, bit15 is ignored and the pixel is shown as-is.
  - hs_d, vs_d, act_d are registered alongside.
- Stage 2 (fade, on DCLK_EN):
  - per channel, out = (c * (16 - fade_cur)) >> 4 with a 9-bit intermediate;
  - fade_cur=0 gives identity; fade_cur=15 gives c>>4.
  - Outputs are registered here: R/G/B, HSYNC_OUT, VSYNC_OUT, DE_OUT = stage-1 act.
  - The blank flag forces RGB=0.
- Latency:
  - pixel inputs to outputs = 2 DCLK_EN ticks;
  - ACTIVE/HSYNC/VSYNC to outputs = SYNC_DELAY+2 ticks.
- Fade update:
  - fade_cur <= FADE only on a DCLK_EN tick where vs_d=1 and the previous registered vs_d=0 (rising edge);
  - FADE changes mid-frame never affect the current frame.
  - Simultaneous edge and FADE change: the value present on that tick is captured.
- Outputs hold their value between DCLK_EN ticks. With DCLK_EN held low, nothing changes, including the delay line.

Test Plan:
- Reset then 4 ticks with ACTIVE_IN=1, PIX_IN=16'h7FFF, SYNC_DELAY=2 -> RGB=0, DE=0 until the 4th tick, then R=G=B=31 and DE=1.
- TPE=1, PIX_IN=16'h8000, BD_COLOR=15'h03E0 (R=31), CUR_IN=16'h8000 -> R_OUT=31, G=B=0; with TPE=0 -> RGB=0.
- CUR_IN=16'h001F (B=31), PIX_IN=16'h7C00 (G=31): CUR_PRI=1 -> B=31, G=0; CUR_PRI=0 -> G=31, B=0.
- FADE=8 set mid-frame with PIX_IN G=R=B=31 -> output stays 31 until vs_d rises, then 15 from the next tick; FADE=15 next frame -> 1.
- ACTIVE_IN=0 with DISP=1 and non-zero pixel -> RGB=0, DE=0; DISP=0 in active area -> BD_COLOR shown.
- DCLK_EN high every 4th CLK, HSYNC pulse of 3 ticks -> HSYNC_OUT pulse of exactly 3 ticks, starting SYNC_DELAY+2 ticks later, stable between enables.
